fetch_pc: RTL
=============

FETCH_PC -- requirements
Module: fetch_pc

Interface
REQ-001 SHALL have parameter PC_W, default 10: program counter width in bits.
REQ-002 SHALL have parameter START_ADDR, default 0: PC value loaded on reset and on every Start.
REQ-003 SHALL have port CLK, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port Reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port Start, input, 1: begins program execution; sampled in IDLE or HALTED only.
REQ-006 SHALL have port Halt, input, 1: stops execution at the current PC.
REQ-007 SHALL have port Branch, input, 1: the branch is taken this cycle.
REQ-008 SHALL have port BrRel, input, 1: 1 = relative branch, 0 = absolute branch.
REQ-009 SHALL have port BrTarget, input, 8: the selected branch operand from the branch mux.
REQ-010 SHALL have port PC, output, PC_W: the current instruction address, registered.
REQ-011 SHALL have port Running, output, 1: high while in RUN.
REQ-012 SHALL have port Done, output, 1: high while in HALTED.
REQ-013 SHALL have port InstCnt, output, 16: retired-instruction count, registered.

Function
REQ-014 SHALL implement the states IDLE, RUN and HALTED, with Running and Done decoded from the registered state.
REQ-015 SHALL move IDLE->RUN on Start, load PC=START_ADDR and clear InstCnt on that edge.
REQ-016 SHALL, in RUN, apply priority Halt > Branch > increment each cycle.
REQ-017 SHALL, in RUN with Halt=1, hold PC, move to HALTED on the same edge, and count the halting instruction.
REQ-018 SHALL, in RUN with Branch=1 and Halt=0, load PC from the branch target on the next edge (latency 1).
REQ-019 SHALL form the absolute target as {PC[PC_W-1:8], BrTarget}, i.e. a page-local branch.
REQ-020 SHALL form the relative target as PC + sign-extended BrTarget, modulo 2^PC_W.
REQ-021 SHALL otherwise set PC to PC+1 in RUN, wrapping from 2^PC_W-1 to 0.
REQ-022 SHALL increment InstCnt by 1 on every RUN cycle and saturate it at 16'hFFFF.
REQ-023 SHALL ignore Start while in RUN.
REQ-024 SHALL, in HALTED on Start, return to RUN with PC=START_ADDR and InstCnt=0.
REQ-025 SHALL ignore Branch, BrRel and BrTarget outside RUN, leaving PC unchanged.
REQ-026 SHALL ignore Halt outside RUN.

Reset
REQ-027 SHALL, on Reset=1 at a rising edge, set state=IDLE, PC=START_ADDR, InstCnt=0, Running=0 and Done=0.
REQ-028 SHALL give Reset priority over Start, Halt and Branch in every state, including mid-RUN.

Configuration
REQ-029 SHALL, with macro FETCH_PC_BRANCH_REL_EN defined, honour BrRel as specified in REQ-019 and REQ-020.
REQ-030 SHALL, without FETCH_PC_BRANCH_REL_EN, ignore BrRel and treat every taken branch as absolute; the port remains present.

Structure
REQ-031 SHALL take the state enum (IDLE/RUN/HALTED), the PC_W default and the InstCnt width from the shared package cpu_pkg.
REQ-032 SHALL compute the branch target in one combinational sub-module, branch_target (inputs PC, BrTarget, BrRel; output next target).

Verification
REQ-033 SHALL cover sequential run: Reset, Start, 5 cycles -> PC=5, InstCnt=5, Running=1.
REQ-034 SHALL cover absolute branch: PC=10'h105, Branch=1, BrRel=0, BrTarget=8'h20 -> PC=10'h120 next cycle.
REQ-035 SHALL cover relative branch (macro on): PC=10'h010, BrRel=1, BrTarget=8'hF8 -> PC=10'h008; with macro off, same stimulus -> PC=10'h0F8.
REQ-036 SHALL cover simultaneous events: Halt=1 with Branch=1 at PC=7 -> PC stays 7, Done=1, InstCnt counts the halting cycle.
REQ-037 SHALL cover wrap: PC=10'h3FF, no branch -> PC=0; with InstCnt forced to 16'hFFFF, further RUN cycles -> InstCnt stays 16'hFFFF.
REQ-038 SHALL cover reset mid-RUN: Reset at PC=0x42 -> IDLE, PC=START_ADDR, InstCnt=0; then Start in HALTED -> RUN from START_ADDR.

Source files
------------

// File: rtl/cpu_pkg.sv
//------------------------------------------------------------------------------
// cpu_pkg : fetch-unit state encoding and shared width defaults.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package cpu_pkg;

  localparam int PC_W_DEFAULT = 10;
  localparam int INSTCNT_W    = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/branch_target.sv
//------------------------------------------------------------------------------
// branch_target : page-local absolute or sign-extended relative branch target.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module branch_target
  import cpu_pkg::*;
#(
  parameter int PC_W = PC_W_DEFAULT
) (
  input  logic [PC_W-1:0] PC,
  input  logic [7:0]      BrTarget,
  input  logic            BrRel,
  output logic [PC_W-1:0] Target
);

  logic [PC_W-1:0] w_abs;
  logic [PC_W-1:0] w_offset;

  generate
    if (PC_W > 8) begin : g_wide
      assign w_abs    = {PC[PC_W-1:8], BrTarget};
      assign w_offset = {{(PC_W-8){BrTarget[7]}}, BrTarget};
    end else begin : g_byte
      assign w_abs    = BrTarget;
      assign w_offset = BrTarget;
    end
  endgenerate

  assign Target = BrRel ? (PC + w_offset) : w_abs;

endmodule

`default_nettype wire

// File: rtl/fetch_pc.sv
//------------------------------------------------------------------------------
// fetch_pc : program counter sequencer (IDLE/RUN/HALTED) with retired count.
// FETCH_PC_BRANCH_REL_EN enables relative branches; otherwise all are absolute.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fetch_pc
  import cpu_pkg::*;
#(
  parameter int              PC_W       = PC_W_DEFAULT,
  parameter logic [PC_W-1:0] START_ADDR = '0
) (
  input  logic                 CLK,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic                 Halt,
  input  logic                 Branch,
  input  logic                 BrRel,
  input  logic [7:0]           BrTarget,
  output logic [PC_W-1:0]      PC,
  output logic                 Running,
  output logic                 Done,
  output logic [INSTCNT_W-1:0] InstCnt
);

  fetch_state_t         r_state;
  fetch_state_t         w_state_next;
  logic [PC_W-1:0]      r_pc;
  logic [PC_W-1:0]      w_pc_next;
  logic [PC_W-1:0]      w_target;
  logic [INSTCNT_W-1:0] r_cnt;
  logic [INSTCNT_W-1:0] w_cnt_next;
  logic                 w_rel;

`ifdef FETCH_PC_BRANCH_REL_EN
  assign w_rel = BrRel;
`else
  logic w_unused_brrel;
  assign w_unused_brrel = BrRel;
  assign w_rel          = 1'b0;
`endif

  branch_target #(
    .PC_W (PC_W)
  ) u_branch_target (
    .PC       (r_pc),
    .BrTarget (BrTarget),
    .BrRel    (w_rel),
    .Target   (w_target)
  );

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_state <= ST_IDLE;
      r_pc    <= START_ADDR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_cnt_next   = r_cnt;
    case (r_state)
      ST_IDLE, ST_HALTED: begin
        if (Start) begin
          w_state_next = ST_RUN;
          w_pc_next    = START_ADDR;
          w_cnt_next   = '0;
        end
      end
      ST_RUN: begin
        // Every RUN cycle retires one instruction, including the halting one.
        w_cnt_next = (r_cnt == {INSTCNT_W{1'b1}}) ? r_cnt : r_cnt + {{(INSTCNT_W-1){1'b0}}, 1'b1};
        if (Halt) begin
          w_state_next = ST_HALTED;
        end else if (Branch) begin
          w_pc_next = w_target;
        end else begin
          w_pc_next = r_pc + {{(PC_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign PC      = r_pc;
  assign InstCnt = r_cnt;
  assign Running = (r_state == ST_RUN);
  assign Done    = (r_state == ST_HALTED);

endmodule

`default_nettype wire
